word_streamer: RTL and testbench



---
 rtl/skribble_pkg.sv | 26 ++
 rtl/word_streamer_if.sv | 24 ++
 rtl/word_rom.sv | 47 ++++
 rtl/word_streamer.sv | 100 ++++++++++
 tb/tb_word_streamer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/skribble_pkg.sv
// Shared definitions for the word-game blocks: geometry of the word ROM,
// derived field widths, the ASCII blank character and the streamer state codes.
package skribble_pkg;

    localparam int CHAR_W    = 8;
    localparam int MAX_LEN   = 8;
    localparam int NUM_WORDS = 8;

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int POS_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t ASCII_UNDERSCORE = 8'h5F;

    // Streamer state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/word_streamer_if.sv
// Character stream bundle between the word streamer (master) and the
// display/guess logic (slave).
interface word_streamer_if;
    import skribble_pkg::*;

    char_t char_data;
    logic  char_valid;
    logic  char_ready;
    pos_t  char_pos;
    len_t  word_len;
    logic  busy;
    logic  word_done;

    modport master (
        output char_data, char_valid, char_pos, word_len, busy, word_done,
        input  char_ready
    );

    modport slave (
        input  char_data, char_valid, char_pos, word_len, busy, word_done,
        output char_ready
    );

endinterface

// File: rtl/word_rom.sv
// Combinational word ROM: returns the character at (idx, pos) and the word
// length. Words are stored left-aligned, position 0 in the top byte.
// Indices beyond NUM_WORDS fall back to word 0.
module word_rom
    import skribble_pkg::*;
(
    input  idx_t  idx,
    input  pos_t  pos,
    output char_t ch,
    output len_t  len
);

    logic [MAX_LEN*CHAR_W-1:0] word_bits;
    char_t                     chars [MAX_LEN];
    logic [IDX_W:0]            idx_ext;

    assign idx_ext = {1'b0, idx};

    // Word text and length lookup
    always_comb begin
        word_bits = {"APPLE", 24'h0};
        len       = len_t'(5);
        if (idx_ext < (IDX_W+1)'(NUM_WORDS)) begin
            case (idx)
                idx_t'(0): begin word_bits = {"APPLE",  24'h0}; len = len_t'(5); end
                idx_t'(1): begin word_bits = {"HOUSE",  24'h0}; len = len_t'(5); end
                idx_t'(2): begin word_bits = {"TREE",   32'h0}; len = len_t'(4); end
                idx_t'(3): begin word_bits = {"GUITAR", 16'h0}; len = len_t'(6); end
                idx_t'(4): begin word_bits = {"CAT",    40'h0}; len = len_t'(3); end
                idx_t'(5): begin word_bits = {"PIZZA",  24'h0}; len = len_t'(5); end
                idx_t'(6): begin word_bits = {"ROBOT",  24'h0}; len = len_t'(5); end
                idx_t'(7): begin word_bits = "SUNFLOWR";        len = len_t'(8); end
                default:   begin word_bits = {"APPLE",  24'h0}; len = len_t'(5); end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_char
            assign chars[gi] = word_bits[(MAX_LEN-1-gi)*CHAR_W +: CHAR_W];
        end
    endgenerate

    assign ch = chars[pos];

endmodule

// File: rtl/word_streamer.sv
// Word streamer: on new_game, waits one cycle for the selector's index,
// then streams the selected word one character per valid/ready handshake
// and pulses word_done after the last character is accepted.
// Build option WORD_STREAM_MASK_EN: every character is sent as '_' (0x5F)
// while lengths, positions and timing stay the same.
module word_streamer
    import skribble_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  idx_t                   word_index,
    word_streamer_if.master        bus
);

    logic [1:0] state_reg;
    idx_t       idx_q;
    pos_t       pos_reg;
    len_t       len_reg;
    char_t      data_reg;

    idx_t       rom_idx;
    pos_t       rom_pos;
    char_t      rom_ch;
    len_t       rom_len;
    char_t      load_ch;
    logic       last_pos;

    // ROM address: first character of the incoming word while waiting,
    // otherwise the character after the one currently presented
    always_comb begin
        rom_idx = idx_q;
        rom_pos = pos_t'(pos_reg + 1'b1);
        if (state_reg == ST_WAIT) begin
            rom_idx = word_index;
            rom_pos = '0;
        end
    end

    word_rom u_rom (
        .idx (rom_idx),
        .pos (rom_pos),
        .ch  (rom_ch),
        .len (rom_len)
    );

`ifdef WORD_STREAM_MASK_EN
    // The guesser only sees blanks; the ROM character is deliberately dropped
    logic rom_ch_unused;
    assign rom_ch_unused = ^rom_ch;
    assign load_ch       = ASCII_UNDERSCORE;
`else
    assign load_ch = rom_ch;
`endif

    assign last_pos = (pos_reg == pos_t'(len_reg - 1'b1));

    // Control FSM and stream registers; new_game restarts from any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_q     <= '0;
            pos_reg   <= '0;
            len_reg   <= '0;
            data_reg  <= '0;
        end else if (new_game) begin
            state_reg <= ST_WAIT;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    idx_q     <= word_index;
                    len_reg   <= rom_len;
                    pos_reg   <= '0;
                    data_reg  <= load_ch;
                    state_reg <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (bus.char_ready) begin
                        if (last_pos) begin
                            state_reg <= ST_DONE;
                        end else begin
                            pos_reg  <= pos_t'(pos_reg + 1'b1);
                            data_reg <= load_ch;
                        end
                    end
                end
                ST_DONE:  state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.char_data  = data_reg;
    assign bus.char_valid = (state_reg == ST_STREAM);
    assign bus.char_pos   = pos_reg;
    assign bus.word_len   = len_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.word_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_word_streamer.sv
// Self-checking bench for word_streamer: expected characters are queued when
// a word is requested and popped on each observed handshake.
module tb_word_streamer;
    import skribble_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic [2:0] word_index = 3'd0;

    word_streamer_if bus ();

    word_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .word_index (word_index),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        int         pos;
        int         len;
    } exp_t;

    exp_t  exp_q [$];
    exp_t  mon_e;
    string words [8] = '{"APPLE", "HOUSE", "TREE", "GUITAR",
                         "CAT", "PIZZA", "ROBOT", "SUNFLOWR"};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int hs_count = 0;
    int done_count = 0;

    logic       prev_v = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_d = 8'h0;
    logic [2:0] prev_p = 3'h0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_char(input int idx, input int i);
`ifdef WORD_STREAM_MASK_EN
        return (i < words[idx].len()) ? 8'h5F : 8'h00;
`else
        return words[idx][i];
`endif
    endfunction

    task automatic push_word(input int idx);
        exp_t e;
        for (int i = 0; i < words[idx].len(); i++) begin
            e.ch  = exp_char(idx, i);
            e.pos = i;
            e.len = words[idx].len();
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse new_game, present the index in the WAIT cycle, check the latency
    task automatic start_word(input int idx);
        new_game = 1'b1;
        tick();
        new_game   = 1'b0;
        word_index = 3'(idx);
        push_word(idx);
        check_val("wait_no_valid", bus.char_valid, 0);
        check_val("wait_busy", bus.busy, 1);
        tick();
        check_val("first_valid", bus.char_valid, 1);
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int i;
        d0 = done_count;
        i  = 0;
        while (done_count == d0 && i < bound) begin
            tick();
            i++;
        end
        check_val("done_seen", done_count - d0, 1);
        check_val("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: one line per accepted character, scoreboard compare, stall hold
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (bus.char_valid && prev_v && !prev_hs) begin
                check_val("hold_data", bus.char_data, prev_d);
                check_val("hold_pos", bus.char_pos, prev_p);
            end
            if (bus.char_valid && bus.char_ready) begin
                $display("hs: char 0x%02h pos %0d len %0d", bus.char_data, bus.char_pos, bus.word_len);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_hs", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("char_data", bus.char_data, mon_e.ch);
                    check_val("char_pos", bus.char_pos, mon_e.pos);
                    check_val("word_len", bus.word_len, mon_e.len);
                end
                hs_count++;
                last_hs_cyc = cyc;
            end
            if (bus.word_done) begin
                $display("word_done after %0d handshakes total", hs_count);
                done_count++;
                check_val("done_latency", cyc - last_hs_cyc, 1);
                check_val("done_queue_empty", exp_q.size(), 0);
            end
            prev_v  = bus.char_valid;
            prev_hs = bus.char_valid && bus.char_ready;
            prev_d  = bus.char_data;
            prev_p  = bus.char_pos;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         hs0;
        int         d0;
        int         k;
        logic [3:0] pat;

        bus.char_ready = 1'b0;
        tick();
        tick();
        check_val("rst_valid", bus.char_valid, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_data", bus.char_data, 0);
        check_val("rst_pos", bus.char_pos, 0);
        check_val("rst_len", bus.word_len, 0);
        check_val("rst_done", bus.word_done, 0);
        rst = 1'b0;
        tick();

        // Basic stream: CAT with ready held high
        bus.char_ready = 1'b1;
        hs0 = hs_count;
        start_word(4);
        check_val("basic_first_char", bus.char_data, exp_char(4, 0));
        wait_done(40);
        check_val("basic_hs_count", hs_count - hs0, 3);
        check_val("basic_busy_after", bus.busy, 0);
        check_val("basic_done_low", bus.word_done, 0);
        check_val("basic_len_keep", bus.word_len, 3);

        // Backpressure: TREE with ready pattern 1,0,0,1
        tick();
        pat = 4'b1001;
        hs0 = hs_count;
        d0  = done_count;
        start_word(2);
        k = 0;
        while (done_count == d0 && k < 60) begin
            bus.char_ready = pat[3 - (k % 4)];
            tick();
            k++;
        end
        check_val("bp_done_once", done_count - d0, 1);
        check_val("bp_hs_count", hs_count - hs0, 4);
        check_val("bp_queue_empty", exp_q.size(), 0);
        bus.char_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("bp_no_extra_done", done_count - d0, 1);

        // Max length: SUNFLOWR, no wrap past position 7
        hs0 = hs_count;
        start_word(7);
        wait_done(40);
        check_val("max_hs_count", hs_count - hs0, 8);
        check_val("max_no_wrap", bus.char_valid, 0);
        check_val("max_len_keep", bus.word_len, 8);

        // Abort GUITAR at position 2, restart with APPLE
        start_word(3);
        k = 0;
        while (bus.char_pos != 3'd2 && k < 10) begin
            tick();
            k++;
        end
        check_val("abort_reach_pos2", bus.char_pos, 2);
        bus.char_ready = 1'b0;
        new_game   = 1'b1;
        word_index = 3'd0;
        d0 = done_count;
        tick();
        new_game = 1'b0;
        exp_q.delete();
        check_val("abort_valid_drop", bus.char_valid, 0);
        check_val("abort_busy", bus.busy, 1);
        check_val("abort_no_done", bus.word_done, 0);
        push_word(0);
        bus.char_ready = 1'b1;
        tick();
        check_val("abort_restart_valid", bus.char_valid, 1);
        check_val("abort_restart_pos", bus.char_pos, 0);
        wait_done(40);
        check_val("abort_done_count", done_count - d0, 1);

        // HOUSE (all blanks when the mask option is built in)
        start_word(1);
        wait_done(40);
        check_val("house_len", bus.word_len, 5);

        // Mid-stream reset takes effect without a clock edge
        start_word(6);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_valid", bus.char_valid, 0);
        check_val("midrst_busy", bus.busy, 0);
        check_val("midrst_data", bus.char_data, 0);
        check_val("midrst_pos", bus.char_pos, 0);
        check_val("midrst_len", bus.word_len, 0);
        check_val("midrst_done", bus.word_done, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("idle_after_rst", bus.char_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
